dec_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource among 16 requesters.
- Produces the winner as a 4-bit index plus the matching 16-bit one-hot grant (4-to-16 decode of the index).
- Sits in front of the shared resource; each requester owns one Req bit and drives a common Done strobe when finished.
- Per-grant hold counter prevents any requester from starving the others.

---
 rtl/dec_rr_arbiter_if.sv | 33 +++
 rtl/dec_rr_arbiter.sv | 111 +++++++++++
 tb/tb_dec_rr_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dec_rr_arbiter_if.sv
// Request/grant bundle between 16 requesters and dec_rr_arbiter.
// Lock exists only when ARB_LOCK_EN is defined.
interface dec_rr_arbiter_if;
  logic [15:0] Req;
  logic        Done;
`ifdef ARB_LOCK_EN
  logic        Lock;
`endif
  logic [15:0] Gnt;
  logic [3:0]  Gnt_Idx;
  logic        Gnt_Valid;
  logic        Timeout;

`ifdef ARB_LOCK_EN
  modport master (
    output Req, Done, Lock,
    input  Gnt, Gnt_Idx, Gnt_Valid, Timeout
  );
  modport slave (
    input  Req, Done, Lock,
    output Gnt, Gnt_Idx, Gnt_Valid, Timeout
  );
`else
  modport master (
    output Req, Done,
    input  Gnt, Gnt_Idx, Gnt_Valid, Timeout
  );
  modport slave (
    input  Req, Done,
    output Gnt, Gnt_Idx, Gnt_Valid, Timeout
  );
`endif
endinterface

// File: rtl/dec_rr_arbiter.sv
// 16-way round-robin arbiter with binary + one-hot grant and per-grant hold limit.
// Optional ARB_LOCK_EN adds a Lock input that pins the grant until Done.
module dec_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  dec_rr_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             state_q, state_d;
  logic [3:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        gnt_q, gnt_d;
  logic [3:0]         idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;

  logic               win_found;
  logic [3:0]         win_idx;
  logic               rel_done, rel_wd, rel_to, rel_any;

  // First requester at or after ptr_q, wrapping mod 16.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int i = 0; i < 16; i++) begin
      if (!win_found && bus.Req[ptr_q + 4'(i)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + 4'(i);
      end
    end
  end

  always_comb begin
    rel_done = bus.Done;
    rel_wd   = ~bus.Req[idx_q];
    rel_to   = (HOLD_MAX != 0) && (cnt_q == CNT_W'(HOLD_MAX));
`ifdef ARB_LOCK_EN
    if (bus.Lock) begin
      rel_wd = 1'b0;
      rel_to = 1'b0;
    end
`endif
    rel_any = rel_done | rel_wd | rel_to;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StGrant;
          idx_d   = win_idx;
          gnt_d   = 16'h0001 << win_idx;
          valid_d = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      StGrant: begin
        if (rel_any) begin
          state_d   = StIdle;
          gnt_d     = '0;
          valid_d   = 1'b0;
          ptr_d     = idx_q + 4'd1;
          cnt_d     = '0;
          // Done or withdraw take precedence; only a pure hold-limit release flags Timeout.
          timeout_d = rel_to & ~rel_done & ~rel_wd;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.Gnt       = gnt_q;
  assign bus.Gnt_Idx   = idx_q;
  assign bus.Gnt_Valid = valid_q;
  assign bus.Timeout   = timeout_q;

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Directed bench for dec_rr_arbiter; expected outputs queued per step and checked after the edge.
module tb_dec_rr_arbiter;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  dec_rr_arbiter_if bus ();

  dec_rr_arbiter #(
    .HOLD_MAX (8),
    .CNT_W    (8)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       valid;
    logic [3:0] idx;
    logic       to;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic expect_out(input logic v, input logic [3:0] idx, input logic to,
                            input string tag);
    exp_t e;
    e.valid = v;
    e.idx   = idx;
    e.to    = to;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [15:0] eg;
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: got %0d entries want >0", sb.size());
    end
    if (sb.size() != 0) begin
      e  = sb.pop_front();
      eg = e.valid ? (16'h0001 << e.idx) : 16'h0000;
      n_cmp++;
      assert (bus.Gnt === eg) else begin
        n_fail++;
        $error("FAIL %s gnt: got %h want %h", e.tag, bus.Gnt, eg);
      end
      n_cmp++;
      assert (bus.Gnt_Idx === e.idx) else begin
        n_fail++;
        $error("FAIL %s gnt_idx: got %0d want %0d", e.tag, bus.Gnt_Idx, e.idx);
      end
      n_cmp++;
      assert (bus.Gnt_Valid === e.valid) else begin
        n_fail++;
        $error("FAIL %s gnt_valid: got %b want %b", e.tag, bus.Gnt_Valid, e.valid);
      end
      n_cmp++;
      assert (bus.Timeout === e.to) else begin
        n_fail++;
        $error("FAIL %s timeout: got %b want %b", e.tag, bus.Timeout, e.to);
      end
    end
  endtask

  // Drive inputs for one cycle, queue the outputs expected after the next edge, then check.
  task automatic step(input logic [15:0] req, input logic done, input logic v,
                      input logic [3:0] idx, input logic to, input string tag);
    bus.Req  = req;
    bus.Done = done;
    expect_out(v, idx, to, tag);
    @(posedge Clk);
    #1;
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Req  = '0;
    bus.Done = 1'b0;
`ifdef ARB_LOCK_EN
    bus.Lock = 1'b0;
`endif
    repeat (2) @(posedge Clk);
    #1;
    expect_out(1'b0, 4'd0, 1'b0, "reset");
    check_out();
    #2 Rst = 1'b0;

    // Async reset in the middle of a grant
    step(16'h0008, 1'b0, 1'b1, 4'd3, 1'b0, "t1_grant3");
    step(16'h0008, 1'b0, 1'b1, 4'd3, 1'b0, "t1_hold3");
    #2 Rst = 1'b1;
    #1;
    expect_out(1'b0, 4'd0, 1'b0, "t1_async_rst");
    check_out();
    #2 Rst = 1'b0;
    step(16'h0001, 1'b0, 1'b1, 4'd0, 1'b0, "t1_first_grant");
    step(16'h0001, 1'b1, 1'b0, 4'd0, 1'b0, "t1_rel0");

    // Single requester released by Done after 3 cycles
    step(16'h0020, 1'b0, 1'b1, 4'd5, 1'b0, "t2_grant5");
    step(16'h0020, 1'b0, 1'b1, 4'd5, 1'b0, "t2_hold5a");
    step(16'h0020, 1'b0, 1'b1, 4'd5, 1'b0, "t2_hold5b");
    step(16'h0020, 1'b1, 1'b0, 4'd5, 1'b0, "t2_rel5");
    step(16'h0041, 1'b0, 1'b1, 4'd6, 1'b0, "t2_ptr6");
    step(16'h0041, 1'b1, 1'b0, 4'd6, 1'b0, "t2_rel6");
    step(16'h0000, 1'b1, 1'b0, 4'd6, 1'b0, "idle_done_ignored");

    // Wrap between bits 15 and 0
    for (int k = 0; k < 4; k++) begin
      step(16'h8001, 1'b0, 1'b1, (k % 2 == 0) ? 4'd15 : 4'd0, 1'b0, "t3_grant");
      step(16'h8001, 1'b1, 1'b0, (k % 2 == 0) ? 4'd15 : 4'd0, 1'b0, "t3_rel");
    end

    // Hold-limit release alternates between the two requesters
    step(16'h0104, 1'b0, 1'b1, 4'd2, 1'b0, "t4_grant2");
    for (int k = 0; k < 7; k++) step(16'h0104, 1'b0, 1'b1, 4'd2, 1'b0, "t4_hold2");
    step(16'h0104, 1'b0, 1'b0, 4'd2, 1'b1, "t4_timeout2");
    step(16'h0104, 1'b0, 1'b1, 4'd8, 1'b0, "t4_grant8");
    for (int k = 0; k < 7; k++) step(16'h0104, 1'b0, 1'b1, 4'd8, 1'b0, "t4_hold8");
    step(16'h0104, 1'b0, 1'b0, 4'd8, 1'b1, "t4_timeout8");
    step(16'h0104, 1'b0, 1'b1, 4'd2, 1'b0, "t4_regrant2");
    step(16'h0104, 1'b1, 1'b0, 4'd2, 1'b0, "t4_rel_done");

    // Withdraw with Done, withdraw alone, Done at the hold limit
    step(16'h0008, 1'b0, 1'b1, 4'd3, 1'b0, "t5_grant3");
    step(16'h0000, 1'b1, 1'b0, 4'd3, 1'b0, "t5_wd_done");
    step(16'h0018, 1'b0, 1'b1, 4'd4, 1'b0, "t5_ptr4");
    step(16'h0008, 1'b0, 1'b0, 4'd4, 1'b0, "t5_withdraw");
    step(16'h0008, 1'b0, 1'b1, 4'd3, 1'b0, "t5_grant3b");
    for (int k = 0; k < 7; k++)
      step((k % 2 == 0) ? 16'h8808 : 16'h0008, 1'b0, 1'b1, 4'd3, 1'b0, "t5_hold_noise");
    step(16'h0008, 1'b1, 1'b0, 4'd3, 1'b0, "t5_done_at_max");

`ifdef ARB_LOCK_EN
    // Lock suppresses withdraw and hold-limit release; Done still releases
    step(16'h0010, 1'b0, 1'b1, 4'd4, 1'b0, "t6_grant4");
    bus.Lock = 1'b1;
    for (int k = 0; k < 11; k++) step(16'h0000, 1'b0, 1'b1, 4'd4, 1'b0, "t6_locked");
    step(16'h0000, 1'b1, 1'b0, 4'd4, 1'b0, "t6_done_rel");
    bus.Lock = 1'b0;
    step(16'h0000, 1'b0, 1'b0, 4'd4, 1'b0, "t6_idle");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
